// File: rtl/qdrc_sram_pkg.sv
// Shared types and constants for the QDR-II burst-of-4 SRAM responder.
package qdrc_sram_pkg;

    localparam int BURST_WORDS  = 4;
    localparam int WORD_B0_RISE = 0;
    localparam int WORD_B0_FALL = 1;
    localparam int WORD_B1_RISE = 2;
    localparam int WORD_B1_FALL = 3;

    typedef enum logic [1:0] {
        W_IDLE,
        W_BEAT0,
        W_BEAT1
    } wr_state_e;

endpackage

// File: rtl/qdrc_sram_rd_pipe.sv
// Fixed-latency read return path: {valid, burst} delay line feeding a two-beat serializer.
// Optional per-bit extra-cycle skew stage enabled by QDRC_SRAM_SKEW_EN.
module qdrc_sram_rd_pipe
    import qdrc_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 18,
    parameter int                    READ_LATENCY = 9,
    parameter logic [DATA_WIDTH-1:0] SKEW_MASK    = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [BURST_WORDS*DATA_WIDTH-1:0] in_burst,
    output logic [DATA_WIDTH-1:0]             q_rise,
    output logic [DATA_WIDTH-1:0]             q_fall,
    output logic                              q_valid
);

    // One cycle of the latency is spent in the output register, so the line is one shorter.
    localparam int STAGES = READ_LATENCY - 1;

`ifdef QDRC_SRAM_SKEW_EN
    localparam bit SKEW_ON = 1'b1;
`else
    localparam bit SKEW_ON = 1'b0;
`endif

    logic                              vld_p   [STAGES];
    logic [BURST_WORDS*DATA_WIDTH-1:0] burst_p [STAGES];
    logic [DATA_WIDTH-1:0]             hi_rise, hi_fall;
    logic [DATA_WIDTH-1:0]             out_rise, out_fall;
    logic                              out_vld, beat1_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= in_valid;
            for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        burst_p[0] <= in_burst;
        for (int i = 1; i < STAGES; i++) burst_p[i] <= burst_p[i-1];
        if (vld_p[STAGES-1]) begin
            hi_rise <= burst_p[STAGES-1][WORD_B1_RISE*DATA_WIDTH +: DATA_WIDTH];
            hi_fall <= burst_p[STAGES-1][WORD_B1_FALL*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Output stage: beat0 on the arrival cycle, beat1 from the held copy on the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_rise   <= '0;
            out_fall   <= '0;
            out_vld    <= 1'b0;
            beat1_pend <= 1'b0;
        end else if (vld_p[STAGES-1]) begin
            out_rise   <= burst_p[STAGES-1][WORD_B0_RISE*DATA_WIDTH +: DATA_WIDTH];
            out_fall   <= burst_p[STAGES-1][WORD_B0_FALL*DATA_WIDTH +: DATA_WIDTH];
            out_vld    <= 1'b1;
            beat1_pend <= 1'b1;
        end else if (beat1_pend) begin
            out_rise   <= hi_rise;
            out_fall   <= hi_fall;
            out_vld    <= 1'b1;
            beat1_pend <= 1'b0;
        end else begin
            out_rise   <= '0;
            out_fall   <= '0;
            out_vld    <= 1'b0;
        end
    end

    assign q_valid = out_vld;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        if (SKEW_ON && SKEW_MASK[i]) begin : g_skew
            logic rise_d, fall_d;
            always_ff @(posedge clk) begin
                if (reset) begin
                    rise_d <= 1'b0;
                    fall_d <= 1'b0;
                end else begin
                    rise_d <= out_rise[i];
                    fall_d <= out_fall[i];
                end
            end
            assign q_rise[i] = rise_d;
            assign q_fall[i] = fall_d;
        end else begin : g_nom
            assign q_rise[i] = out_rise[i];
            assign q_fall[i] = out_fall[i];
        end
    end

endmodule

// File: rtl/qdrc_phy_sram_responder.sv
// QDR-II burst-of-4 SRAM responder on the PHY's SDR-split pins: masked burst writes, fixed-latency reads.
// Define QDRC_SRAM_SKEW_EN to delay bits selected by SKEW_MASK by one extra cycle on q.
module qdrc_phy_sram_responder
    import qdrc_sram_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 18,
    parameter int                    BW_WIDTH     = 2,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    READ_LATENCY = 9,
    parameter logic [DATA_WIDTH-1:0] SKEW_MASK    = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  qdr_w_n,
    input  logic                  qdr_r_n,
    input  logic [ADDR_WIDTH-1:0] qdr_sa,
    input  logic [DATA_WIDTH-1:0] qdr_d_rise,
    input  logic [DATA_WIDTH-1:0] qdr_d_fall,
    input  logic [BW_WIDTH-1:0]   qdr_bw_n_rise,
    input  logic [BW_WIDTH-1:0]   qdr_bw_n_fall,
    output logic [DATA_WIDTH-1:0] qdr_q_rise,
    output logic [DATA_WIDTH-1:0] qdr_q_fall,
    output logic                  qdr_q_valid,
    output logic                  cmd_err
);

    localparam int LANE_W  = DATA_WIDTH / BW_WIDTH;
    localparam int BURST_W = BURST_WORDS * DATA_WIDTH;

    wr_state_e             state, state_next;
    logic                  wr_accept, wr_commit, wr_viol;
    logic                  rd_accept, rd_viol, rd_last;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] b0_rise, b0_fall;
    logic [BW_WIDTH-1:0]   b0_bw_rise, b0_bw_fall;
    logic [BURST_W-1:0]    mem [2**ADDR_WIDTH];
    logic [BURST_W-1:0]    rd_burst;

    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        wr_commit  = 1'b0;
        wr_viol    = 1'b0;
        case (state)
            W_IDLE: begin
                if (!qdr_w_n) begin
                    wr_accept  = 1'b1;
                    state_next = W_BEAT0;
                end
            end
            W_BEAT0: begin
                state_next = W_BEAT1;
                wr_viol    = !qdr_w_n;
            end
            W_BEAT1: begin
                // A new command here overlaps the commit cleanly: wr_addr still holds the old address.
                wr_commit  = !reset;
                wr_accept  = !qdr_w_n;
                state_next = qdr_w_n ? W_IDLE : W_BEAT0;
            end
            default: state_next = W_IDLE;
        endcase
    end

    assign rd_accept = !qdr_r_n && !rd_last;
    assign rd_viol   = !qdr_r_n && rd_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= W_IDLE;
            rd_last <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_next;
            rd_last <= rd_accept;
            cmd_err <= cmd_err | wr_viol | rd_viol;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) wr_addr <= qdr_sa;
        if (state == W_BEAT0) begin
            b0_rise    <= qdr_d_rise;
            b0_fall    <= qdr_d_fall;
            b0_bw_rise <= qdr_bw_n_rise;
            b0_bw_fall <= qdr_bw_n_fall;
        end
    end

    // Beat1 words come straight from the pins in the commit cycle; masked lanes are left untouched.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int l = 0; l < BW_WIDTH; l++) begin
                if (!b0_bw_rise[l])
                    mem[wr_addr][WORD_B0_RISE*DATA_WIDTH + l*LANE_W +: LANE_W] <= b0_rise[l*LANE_W +: LANE_W];
                if (!b0_bw_fall[l])
                    mem[wr_addr][WORD_B0_FALL*DATA_WIDTH + l*LANE_W +: LANE_W] <= b0_fall[l*LANE_W +: LANE_W];
                if (!qdr_bw_n_rise[l])
                    mem[wr_addr][WORD_B1_RISE*DATA_WIDTH + l*LANE_W +: LANE_W] <= qdr_d_rise[l*LANE_W +: LANE_W];
                if (!qdr_bw_n_fall[l])
                    mem[wr_addr][WORD_B1_FALL*DATA_WIDTH + l*LANE_W +: LANE_W] <= qdr_d_fall[l*LANE_W +: LANE_W];
            end
        end
    end

    assign rd_burst = mem[qdr_sa];

    qdrc_sram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY),
        .SKEW_MASK   (SKEW_MASK)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .in_valid(rd_accept),
        .in_burst(rd_burst),
        .q_rise  (qdr_q_rise),
        .q_fall  (qdr_q_fall),
        .q_valid (qdr_q_valid)
    );

endmodule

// File: tb/tb_qdrc_phy_sram_responder.sv
// Bench for qdrc_phy_sram_responder: write/read vector table plus protocol corner sequences.
module tb_qdrc_phy_sram_responder;

    localparam int RL = 9;
`ifdef QDRC_SRAM_SKEW_EN
    localparam logic [17:0] SKM = 18'h00001;
`else
    localparam logic [17:0] SKM = 18'h00000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        qdr_w_n = 1'b1, qdr_r_n = 1'b1;
    logic [7:0]  qdr_sa = '0;
    logic [17:0] qdr_d_rise = '0, qdr_d_fall = '0;
    logic [1:0]  qdr_bw_n_rise = 2'b11, qdr_bw_n_fall = 2'b11;
    logic [17:0] qdr_q_rise, qdr_q_fall;
    logic        qdr_q_valid, cmd_err;

    always #5 clk = ~clk;

    qdrc_phy_sram_responder #(
        .DATA_WIDTH(18), .BW_WIDTH(2), .ADDR_WIDTH(8), .READ_LATENCY(RL), .SKEW_MASK(SKM)
    ) dut (
        .clk(clk), .reset(reset), .qdr_w_n(qdr_w_n), .qdr_r_n(qdr_r_n), .qdr_sa(qdr_sa),
        .qdr_d_rise(qdr_d_rise), .qdr_d_fall(qdr_d_fall),
        .qdr_bw_n_rise(qdr_bw_n_rise), .qdr_bw_n_fall(qdr_bw_n_fall),
        .qdr_q_rise(qdr_q_rise), .qdr_q_fall(qdr_q_fall), .qdr_q_valid(qdr_q_valid),
        .cmd_err(cmd_err)
    );

    typedef struct {
        int          cyc;
        logic [17:0] r;
        logic [17:0] f;
    } beat_t;

    typedef struct {
        logic [7:0]  sa;
        logic [17:0] d0, d1, d2, d3;
        logic [1:0]  bwr, bwf;
        logic [17:0] e0, e1, e2, e3;
    } vec_t;

    beat_t sb[$];
    vec_t  vecs[6];
    int    cyc = 0;
    int    n_tests = 0, n_fail = 0;
    bit    mon_en = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    // Scoreboard monitor: expected beat or idle every cycle, with the skew mask applied as a one-cycle lag.
    initial begin
        logic        rst_seen, now_v;
        logic [17:0] now_r, now_f, prev_r, prev_f;
        prev_r = '0;
        prev_f = '0;
        forever begin
            @(posedge clk);
            cyc++;
            rst_seen = reset;
            @(negedge clk);
            if (rst_seen) begin
                sb.delete();
                prev_r = '0;
                prev_f = '0;
            end
            now_v = 1'b0;
            now_r = '0;
            now_f = '0;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_missed cyc=%0d act=none exp_cyc=%0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                now_v = 1'b1;
                now_r = sb[0].r;
                now_f = sb[0].f;
                void'(sb.pop_front());
            end
            if (mon_en) begin
                chk("q_valid", 32'(qdr_q_valid), 32'(now_v));
                chk("q_rise", 32'(qdr_q_rise), 32'((now_r & ~SKM) | (prev_r & SKM)));
                chk("q_fall", 32'(qdr_q_fall), 32'((now_f & ~SKM) | (prev_f & SKM)));
            end
            prev_r = now_r;
            prev_f = now_f;
        end
    end

    task automatic drive(input logic w, input logic r, input logic [7:0] a,
                         input logic [17:0] dr, input logic [17:0] df,
                         input logic [1:0] bwr, input logic [1:0] bwf);
        qdr_w_n = w;
        qdr_r_n = r;
        qdr_sa = a;
        qdr_d_rise = dr;
        qdr_d_fall = df;
        qdr_bw_n_rise = bwr;
        qdr_bw_n_fall = bwf;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 8'h00, '0, '0, 2'b11, 2'b11);
    endtask

    task automatic push_rd(input logic [17:0] e0, input logic [17:0] e1,
                           input logic [17:0] e2, input logic [17:0] e3);
        sb.push_back('{cyc + RL, e0, e1});
        sb.push_back('{cyc + RL + 1, e2, e3});
    endtask

    task automatic do_read(input logic [7:0] a, input logic [17:0] e0, input logic [17:0] e1,
                           input logic [17:0] e2, input logic [17:0] e3);
        push_rd(e0, e1, e2, e3);
        drive(1'b1, 1'b0, a, '0, '0, 2'b11, 2'b11);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [17:0] d0, input logic [17:0] d1,
                            input logic [17:0] d2, input logic [17:0] d3,
                            input logic [1:0] bwr, input logic [1:0] bwf);
        drive(1'b0, 1'b1, a, '0, '0, 2'b11, 2'b11);
        drive(1'b1, 1'b1, 8'h00, d0, d1, bwr, bwf);
        drive(1'b1, 1'b1, 8'h00, d2, d3, bwr, bwf);
    endtask

    task automatic set_vec(input int i, input logic [7:0] a,
                           input logic [17:0] d0, input logic [17:0] d1, input logic [17:0] d2, input logic [17:0] d3,
                           input logic [1:0] bwr, input logic [1:0] bwf,
                           input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2, input logic [17:0] e3);
        vecs[i] = '{a, d0, d1, d2, d3, bwr, bwf, e0, e1, e2, e3};
    endtask

    initial begin
        set_vec(0, 8'h05, 18'h00000, 18'h3FFFF, 18'h15555, 18'h2AAAA, 2'b00, 2'b00,
                          18'h00000, 18'h3FFFF, 18'h15555, 18'h2AAAA);
        set_vec(1, 8'h05, 18'h00000, 18'h00000, 18'h00000, 18'h00000, 2'b01, 2'b00,
                          18'h00000, 18'h00000, 18'h00155, 18'h00000);
        set_vec(2, 8'hA3, 18'h12345, 18'h0ABCD, 18'h3FFFF, 18'h00001, 2'b00, 2'b00,
                          18'h12345, 18'h0ABCD, 18'h3FFFF, 18'h00001);
        set_vec(3, 8'hA3, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 2'b10, 2'b11,
                          18'h123FF, 18'h0ABCD, 18'h3FFFF, 18'h00001);
        set_vec(4, 8'hFF, 18'h00001, 18'h00002, 18'h00003, 18'h00004, 2'b00, 2'b00,
                          18'h00001, 18'h00002, 18'h00003, 18'h00004);
        set_vec(5, 8'h40, 18'h3FFFF, 18'h00000, 18'h3FFFF, 18'h00000, 2'b00, 2'b00,
                          18'h3FFFF, 18'h00000, 18'h3FFFF, 18'h00000);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        chk("rst_q_rise", 32'(qdr_q_rise), 32'h0);
        chk("rst_q_fall", 32'(qdr_q_fall), 32'h0);
        chk("rst_q_valid", 32'(qdr_q_valid), 32'h0);
        chk("rst_cmd_err", 32'(cmd_err), 32'h0);
        idle(2);

        for (int i = 0; i < 6; i++) begin
            do_write(vecs[i].sa, vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].bwr, vecs[i].bwf);
            do_read(vecs[i].sa, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
            idle(1);
        end

        // Same-cycle read and write to 0x10: old data first, new data three cycles later.
        do_write(8'h10, 18'h0AAAA, 18'h15555, 18'h2AAAA, 18'h35555, 2'b00, 2'b00);
        idle(2);
        push_rd(18'h0AAAA, 18'h15555, 18'h2AAAA, 18'h35555);
        drive(1'b0, 1'b0, 8'h10, '0, '0, 2'b11, 2'b11);
        drive(1'b1, 1'b1, 8'h00, 18'h00F0F, 18'h3F0F0, 2'b00, 2'b00);
        drive(1'b1, 1'b1, 8'h00, 18'h12121, 18'h21212, 2'b00, 2'b00);
        do_read(8'h10, 18'h00F0F, 18'h3F0F0, 18'h12121, 18'h21212);
        idle(3);
        chk("err_clean", 32'(cmd_err), 32'h0);

        // Back-to-back reads: second is dropped and flags cmd_err.
        push_rd(18'h123FF, 18'h0ABCD, 18'h3FFFF, 18'h00001);
        drive(1'b1, 1'b0, 8'hA3, '0, '0, 2'b11, 2'b11);
        drive(1'b1, 1'b0, 8'hFF, '0, '0, 2'b11, 2'b11);
        chk("err_rd_set", 32'(cmd_err), 32'h1);
        idle(14);
        chk("err_rd_hold", 32'(cmd_err), 32'h1);

        // Reset during a write's beat0 with a read in flight.
        do_read(8'h10, 18'h00F0F, 18'h3F0F0, 18'h12121, 18'h21212);
        idle(1);
        drive(1'b0, 1'b1, 8'h05, '0, '0, 2'b11, 2'b11);
        reset = 1'b1;
        drive(1'b1, 1'b1, 8'h00, 18'h3FFFF, 18'h3FFFF, 2'b00, 2'b00);
        reset = 1'b0;
        chk("mid_rst_q_rise", 32'(qdr_q_rise), 32'h0);
        chk("mid_rst_q_fall", 32'(qdr_q_fall), 32'h0);
        chk("mid_rst_q_valid", 32'(qdr_q_valid), 32'h0);
        chk("mid_rst_cmd_err", 32'(cmd_err), 32'h0);
        drive(1'b1, 1'b1, 8'h00, 18'h3FFFF, 18'h3FFFF, 2'b00, 2'b00);
        idle(12);
        do_read(8'h05, 18'h00000, 18'h00000, 18'h00155, 18'h00000);
        idle(3);
        do_read(8'h10, 18'h00F0F, 18'h3F0F0, 18'h12121, 18'h21212);
        idle(3);

        // Write restarted from W_BEAT1 is legal and both bursts land.
        drive(1'b0, 1'b1, 8'h30, '0, '0, 2'b11, 2'b11);
        drive(1'b1, 1'b1, 8'h00, 18'h01234, 18'h05678, 2'b00, 2'b00);
        drive(1'b0, 1'b1, 8'h31, 18'h09ABC, 18'h0DEF0, 2'b00, 2'b00);
        drive(1'b1, 1'b1, 8'h00, 18'h3FEDC, 18'h3BA98, 2'b00, 2'b00);
        drive(1'b1, 1'b1, 8'h00, 18'h37654, 18'h33210, 2'b00, 2'b00);
        do_read(8'h30, 18'h01234, 18'h05678, 18'h09ABC, 18'h0DEF0);
        idle(1);
        do_read(8'h31, 18'h3FEDC, 18'h3BA98, 18'h37654, 18'h33210);
        idle(2);
        chk("err_restart_ok", 32'(cmd_err), 32'h0);

        // Write command during W_BEAT0 is ignored and flags cmd_err.
        drive(1'b0, 1'b1, 8'h20, '0, '0, 2'b11, 2'b11);
        drive(1'b0, 1'b1, 8'h21, 18'h11111, 18'h22222, 2'b00, 2'b00);
        drive(1'b1, 1'b1, 8'h00, 18'h33333, 18'h04444, 2'b00, 2'b00);
        chk("err_wr_set", 32'(cmd_err), 32'h1);
        do_read(8'h20, 18'h11111, 18'h22222, 18'h33333, 18'h04444);

        for (int i = 0; i < 60 && sb.size() > 0; i++) idle(1);
        idle(2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain act=%0d pending exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
